// File: rtl/mem_write_checker_if.sv
// Store-port bundle snooped by mem_write_checker: the core drives it (master),
// the checker only observes it (slave).
interface mem_write_checker_if #(
  parameter int WIDTH = 32
);
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker.sv
// End-of-run checker for the MIPS data-memory write port.
// Declares PASS on a correct sentinel store, FAIL on a wrong sentinel or too
// few stores, TIMEOUT when the watchdog expires. Terminal states hold until
// reset. Define MEM_WRITE_CHECKER_TRACE_EN to build the ring of recent stores;
// without it the trace outputs read as 0.
module mem_write_checker #(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] DONE_ADR       = 128,
  parameter logic [WIDTH-1:0] DONE_DATA      = 7,
  parameter int               MIN_WRITES     = 1,
  parameter int               TIMEOUT_CYCLES = 10000,
  parameter int               CNT_W          = 16,
  parameter int               DEPTH          = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_write_checker_if.slave       bus,
  input  logic [$clog2(DEPTH)-1:0] trace_idx,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [CNT_W-1:0]         write_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [WIDTH-1:0]         trace_adr,
  output logic [WIDTH-1:0]         trace_data,
  output logic [$clog2(DEPTH):0]   trace_valid
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] write_count_q, write_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             sentinel, wd_fire, rec;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      write_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      write_count_q <= write_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Next state and counters; everything freezes once a verdict is reached.
  // The watchdog edge does not advance cycle_count, so it freezes at
  // TIMEOUT_CYCLES-1; the sentinel wins over an expiring watchdog.
  always_comb begin
    state_d       = state_q;
    write_count_d = write_count_q;
    cycle_count_d = cycle_count_q;
    sentinel      = 1'b0;
    wd_fire       = 1'b0;
    rec           = 1'b0;
    if (state_q == S_RUN) begin
      rec      = bus.memwrite;
      sentinel = bus.memwrite && (bus.dataadr == DONE_ADR);
      wd_fire  = !sentinel && (TIMEOUT_CYCLES != 0) &&
                 (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1));
      if (bus.memwrite && (write_count_q != '1))
        write_count_d = write_count_q + CNT_W'(1);
      if (!wd_fire && (cycle_count_q != '1))
        cycle_count_d = cycle_count_q + CNT_W'(1);
      if (sentinel)
        state_d = ((bus.writedata == DONE_DATA) &&
                   (write_count_d >= CNT_W'(MIN_WRITES))) ? S_PASS : S_FAIL;
      else if (wd_fire)
        state_d = S_TIMEOUT;
    end
  end

  assign done        = (state_q != S_RUN);
  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign timeout     = (state_q == S_TIMEOUT);
  assign write_count = write_count_q;
  assign cycle_count = cycle_count_q;

`ifdef MEM_WRITE_CHECKER_TRACE_EN
  logic [WIDTH-1:0] ring_adr_q [DEPTH];
  logic [WIDTH-1:0] ring_dat_q [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, rd_slot;
  logic [IDX_W:0]   valid_q, valid_d;

  // Ring storage and pointer; wr_ptr_q always names the next slot to fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_adr_q[i] <= '0;
        ring_dat_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      if (rec) begin
        ring_adr_q[wr_ptr_q] <= bus.dataadr;
        ring_dat_q[wr_ptr_q] <= bus.writedata;
      end
    end
  end

  // Pointer advance (wraps naturally) and saturating fill level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    if (rec) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (valid_q != (IDX_W+1)'(DEPTH)) valid_d = valid_q + (IDX_W+1)'(1);
    end
  end

  // Combinational read: index 0 is the newest entry, unfilled slots read 0.
  always_comb begin
    rd_slot    = wr_ptr_q - IDX_W'(1) - trace_idx;
    trace_adr  = '0;
    trace_data = '0;
    if ({1'b0, trace_idx} < valid_q) begin
      trace_adr  = ring_adr_q[rd_slot];
      trace_data = ring_dat_q[rd_slot];
    end
  end

  assign trace_valid = valid_q;
`else
  logic unused_trace;
  assign unused_trace = ^trace_idx ^ rec;
  assign trace_adr    = '0;
  assign trace_data   = '0;
  assign trace_valid  = '0;
`endif
endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: two instances (MIN_WRITES=1/TIMEOUT=50 and
// MIN_WRITES=4/no watchdog), a behavioural model of verdicts, counters and
// store history checked every negedge, plus literal spot checks.
module tb_mem_write_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_write_checker_if #(.WIDTH(32)) bus_a ();
  mem_write_checker_if #(.WIDTH(32)) bus_b ();

  logic [1:0][2:0]  idx;
  logic [1:0]       done, pass, fail, tmo;
  logic [1:0][15:0] wc, cc;
  logic [1:0][31:0] tadr, tdat;
  logic [1:0][3:0]  tv;

  mem_write_checker #(.MIN_WRITES(1), .TIMEOUT_CYCLES(50)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a), .trace_idx(idx[0]),
    .done(done[0]), .pass(pass[0]), .fail(fail[0]), .timeout(tmo[0]),
    .write_count(wc[0]), .cycle_count(cc[0]),
    .trace_adr(tadr[0]), .trace_data(tdat[0]), .trace_valid(tv[0]));

  mem_write_checker #(.MIN_WRITES(4), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b), .trace_idx(idx[1]),
    .done(done[1]), .pass(pass[1]), .fail(fail[1]), .timeout(tmo[1]),
    .write_count(wc[1]), .cycle_count(cc[1]),
    .trace_adr(tadr[1]), .trace_data(tdat[1]), .trace_valid(tv[1]));

`ifdef MEM_WRITE_CHECKER_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int minw(input int k); return (k == 0) ? 1 : 4; endfunction
  function automatic int tlim(input int k); return (k == 0) ? 50 : 0; endfunction

  // Model: verdict (0 run,1 pass,2 fail,3 timeout), counts, full store history.
  int          ms [2];
  int          mwc[2];
  int          mcc[2];
  int          hn [2];
  logic [31:0] ha [2][64];
  logic [31:0] hd [2][64];

  // Inputs are changed only at negedge+1, so at negedge they still hold what
  // the preceding posedge sampled: advance the model, then compare.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic        mw;
        logic [31:0] adr, dat;
        bit          sent, wd;
        int          tvx;
        logic [31:0] ea, ed;
        mw  = k ? bus_b.memwrite  : bus_a.memwrite;
        adr = k ? bus_b.dataadr   : bus_a.dataadr;
        dat = k ? bus_b.writedata : bus_a.writedata;
        if (rst) begin
          ms[k] = 0; mwc[k] = 0; mcc[k] = 0; hn[k] = 0;
        end else if (ms[k] == 0) begin
          sent = mw && (adr == 32'd128);
          wd   = !sent && (tlim(k) != 0) && (mcc[k] == tlim(k) - 1);
          if (mw) begin
            if (mwc[k] < 65535) mwc[k]++;
            if (hn[k] < 64) begin ha[k][hn[k]] = adr; hd[k][hn[k]] = dat; hn[k]++; end
          end
          if (!wd && mcc[k] < 65535) mcc[k]++;
          if (sent)    ms[k] = (dat == 32'd7 && mwc[k] >= minw(k)) ? 1 : 2;
          else if (wd) ms[k] = 3;
        end
        tvx = TR ? ((hn[k] < 8) ? hn[k] : 8) : 0;
        ea = '0; ed = '0;
        if (int'(idx[k]) < tvx) begin
          ea = ha[k][hn[k] - 1 - int'(idx[k])];
          ed = hd[k][hn[k] - 1 - int'(idx[k])];
        end
        chk($sformatf("i%0d.done", k), 64'(done[k]), 64'(ms[k] != 0));
        chk($sformatf("i%0d.pass", k), 64'(pass[k]), 64'(ms[k] == 1));
        chk($sformatf("i%0d.fail", k), 64'(fail[k]), 64'(ms[k] == 2));
        chk($sformatf("i%0d.timeout", k), 64'(tmo[k]), 64'(ms[k] == 3));
        chk($sformatf("i%0d.write_count", k), 64'(wc[k]), 64'(mwc[k]));
        chk($sformatf("i%0d.cycle_count", k), 64'(cc[k]), 64'(mcc[k]));
        chk($sformatf("i%0d.trace_valid", k), 64'(tv[k]), 64'(tvx));
        chk($sformatf("i%0d.trace_adr", k), 64'(tadr[k]), 64'(ea));
        chk($sformatf("i%0d.trace_data", k), 64'(tdat[k]), 64'(ed));
      end
    end
  end

  task automatic clr();
    bus_a.memwrite = 1'b0; bus_a.dataadr = '0; bus_a.writedata = '0;
    bus_b.memwrite = 1'b0; bus_b.dataadr = '0; bus_b.writedata = '0;
  endtask

  task automatic cyc(input logic mwa, input int aa, input int da,
                     input logic mwb, input int ab, input int db);
    @(negedge clk); #1;
    bus_a.memwrite = mwa; bus_a.dataadr = 32'(aa); bus_a.writedata = 32'(da);
    bus_b.memwrite = mwb; bus_b.dataadr = 32'(ab); bus_b.writedata = 32'(db);
  endtask

  task automatic do_reset();
    @(negedge clk); #1; clr(); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idx = '0; clr();
    repeat (2) @(negedge clk);
    chk("lit.reset_done", 64'(done), 64'(0));
    chk("lit.reset_wc_b", 64'(wc[1]), 64'(0));
    chk("lit.reset_tv_a", 64'(tv[0]), 64'(0));
    #1; rst = 1'b0;

    // A: two stores then good sentinel -> pass; B: 2 of 4 stores -> fail.
    cyc(1, 4, 1,   1, 4, 1);
    cyc(1, 8, 2,   1, 128, 7);
    cyc(1, 128, 7, 0, 0, 0);
    @(negedge clk);
    chk("lit.pass_a", 64'(pass[0]), 64'(1));
    chk("lit.done_a", 64'(done[0]), 64'(1));
    chk("lit.wc_a", 64'(wc[0]), 64'(3));
    chk("lit.minw_fail_b", 64'(fail[1]), 64'(1));
    chk("lit.minw_wc_b", 64'(wc[1]), 64'(2));
    #1; clr();

    // A: wrong sentinel then correct one (ignored); B: 10 stores for the ring.
    do_reset();
    for (int i = 1; i <= 10; i++)
      cyc(i <= 2, 128, (i == 1) ? 6 : 7,  1, i, 100 + i);
    @(negedge clk);
    chk("lit.badsent_fail_a", 64'(fail[0]), 64'(1));
    chk("lit.badsent_pass_a", 64'(pass[0]), 64'(0));
    chk("lit.badsent_wc_a", 64'(wc[0]), 64'(1));
    chk("lit.ring_valid_b", 64'(tv[1]), TR ? 64'(8) : 64'(0));
    #1; clr(); idx[1] = 3'd0;
    @(negedge clk);
    chk("lit.ring0_adr", 64'(tadr[1]), TR ? 64'(10) : 64'(0));
    chk("lit.ring0_dat", 64'(tdat[1]), TR ? 64'(110) : 64'(0));
    #1; idx[1] = 3'd7;
    @(negedge clk);
    chk("lit.ring7_adr", 64'(tadr[1]), TR ? 64'(3) : 64'(0));
    chk("lit.ring7_dat", 64'(tdat[1]), TR ? 64'(103) : 64'(0));
    #1; idx[1] = 3'd2; rst = 1'b1;
    @(negedge clk);
    chk("lit.midreset_tv_b", 64'(tv[1]), 64'(0));
    chk("lit.midreset_adr_b", 64'(tadr[1]), 64'(0));
    chk("lit.midreset_cc_b", 64'(cc[1]), 64'(0));
    chk("lit.midreset_fail_a", 64'(fail[0]), 64'(0));
    #1; rst = 1'b0;
    cyc(0, 0, 0, 1, 20, 5);
    @(negedge clk);
    chk("lit.resume_wc_b", 64'(wc[1]), 64'(1));
    #1; clr(); idx = '0;

    // Watchdog on A; B has none and stays in RUN.
    do_reset();
    repeat (60) @(negedge clk);
    chk("lit.wd_timeout_a", 64'(tmo[0]), 64'(1));
    chk("lit.wd_cc_a", 64'(cc[0]), 64'(49));
    chk("lit.wd_pass_a", 64'(pass[0]), 64'(0));
    chk("lit.nowd_done_b", 64'(done[1]), 64'(0));

    // Sentinel on the same edge the watchdog would expire.
    do_reset();
    repeat (49) @(negedge clk);
    #1; bus_a.memwrite = 1'b1; bus_a.dataadr = 32'd128; bus_a.writedata = 32'd7;
    @(negedge clk);
    chk("lit.race_pass_a", 64'(pass[0]), 64'(1));
    chk("lit.race_timeout_a", 64'(tmo[0]), 64'(0));
    #1; clr();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable end-of-run checker for the MIPS core's data-memory write port. It sits beside `top` and snoops `memwrite`/`dataadr`/`writedata`. It declares PASS when the program writes the configured sentinel value to the sentinel address. It declares FAIL on a wrong sentinel value or too few writes, and TIMEOUT when the watchdog expires. Optionally it keeps a ring buffer of the most recent writes for post-mortem inspection.

## Interface
Parameters:
- `WIDTH`, 32, address/data width.
- `DONE_ADR`, 128, sentinel address.
- `DONE_DATA`, 7, expected sentinel data.
- `MIN_WRITES`, 1, minimum memwrite count (sentinel included) required for PASS.
- `TIMEOUT_CYCLES`, 10000, watchdog limit in cycles; 0 disables the watchdog.
- `CNT_W`, 16, width of the write and cycle counters.
- `DEPTH`, 8, trace ring depth; power of two, at least 2.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `memwrite` in 1: store strobe from the core.
- `dataadr` in WIDTH: store address.
- `writedata` in WIDTH: store data.
- `trace_idx` in log2(DEPTH): trace read index; 0 = most recent write.
- `done` out 1: run finished (any terminal state).
- `pass` out 1: sentinel correct and write count ≥ MIN_WRITES.
- `fail` out 1: sentinel data wrong, or write count < MIN_WRITES.
- `timeout` out 1: watchdog expired before the sentinel.
- `write_count` out CNT_W: memwrite cycles seen in RUN; saturating.
- `cycle_count` out CNT_W: cycles spent in RUN; saturating.
- `trace_adr` out WIDTH: address of the write at `trace_idx`.
- `trace_data` out WIDTH: data of the write at `trace_idx`.
- `trace_valid` out log2(DEPTH)+1: number of valid ring entries; saturates at DEPTH.

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. Reset state is RUN. PASS, FAIL and TIMEOUT are terminal and held until `reset`.
- **In RUN, on each rising edge:**
  - `cycle_count` increments, saturating at 2^CNT_W−1.
  - If `memwrite`: `write_count` increments (saturating) and the trace ring records the write.
  - If `memwrite && dataadr == DONE_ADR`, let n = `write_count`+1 (saturated):
    - `writedata == DONE_DATA` and n ≥ MIN_WRITES → PASS.
    - Otherwise → FAIL.
  - Else, if TIMEOUT_CYCLES ≠ 0 and `cycle_count == TIMEOUT_CYCLES−1` → TIMEOUT.
  - Sentinel detection has priority over timeout when both occur on the same edge.
- Comparisons are full-width equality. The sentinel uses `===`-free RTL equality, so X on inputs is a bench error, not a checker concern.
- In terminal states the counters and trace ring freeze; `memwrite` is ignored.
- Outputs:
  - `done = (state != RUN)`.
  - `pass`, `fail`, `timeout` are one-hot when `done`, and all 0 in RUN.
  - All are registered, decoded from the state register.

## Timing
- **Reset values:**
  - `done`, `pass`, `fail`, `timeout` = 0.
  - `write_count`, `cycle_count` = 0.
  - `trace_valid` = 0.
  - `trace_adr`/`trace_data` = 0.
- **Latency:** the sentinel write sampled at edge k gives `done`/`pass`/`fail` high after edge k, visible in cycle k+1. A negedge-sampling bench sees them in the same clock period.
- **Watchdog:** TIMEOUT is entered on the edge where `cycle_count` equals TIMEOUT_CYCLES−1. `timeout` is high from the TIMEOUT_CYCLES-th cycle after reset release.
- **Trace ring:**
  - Write pointer wraps modulo DEPTH.
  - The read path is combinational from `trace_idx` and the pointer.
  - When `trace_idx ≥ trace_valid`, `trace_adr`/`trace_data` return 0.
- Reset asserted mid-run or in a terminal state clears everything asynchronously and re-enters RUN on the first edge after release.

## Configuration
- `MEM_WRITE_CHECKER_TRACE_EN` defined: the DEPTH-entry trace ring, its pointer and `trace_valid` are built.
- `MEM_WRITE_CHECKER_TRACE_EN` not defined: no ring storage is built, and `trace_adr`, `trace_data`, `trace_valid` are tied to 0. FSM and counters are unchanged.

## Test plan
- **Pass:** writes (4,1), (8,2), then (128,7) with MIN_WRITES=1 → `pass`=1, `done`=1 one cycle after the sentinel edge; `write_count`=3.
- **Wrong sentinel data:** (128,6) → `fail`=1, `pass`=0. A later (128,7) leaves `fail`=1 and `write_count` frozen.
- **MIN_WRITES=4 not met:** writes (4,1), then (128,7) → `fail`=1, `write_count`=2.
- **Watchdog:** TIMEOUT_CYCLES=50, no writes → `timeout`=1 in cycle 50, `cycle_count`=49.
- **Sentinel vs. timeout same edge:** sentinel (128,7) on the TIMEOUT_CYCLES−1 edge → `pass`=1, `timeout`=0.
- **Trace ring (macro on, DEPTH=8):** 10 writes (i,100+i), i=1..10, then reset mid-run:
  - `trace_valid`=8.
  - `trace_idx`=0 → (10,110); `trace_idx`=7 → (3,103).
  - After the reset pulse, all outputs are 0 and RUN resumes.
